// File: rtl/seq_pkg.sv
// Shared encodings and opcode constants for the instruction-cycle sequencer.
package seq_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_NOP   = 4'd0;
  localparam logic [OPW-1:0] OP_STORE = 4'd14;
  localparam logic [OPW-1:0] OP_HLT   = 4'd15;

  // Encoding 7 is unused; the sequencer recovers from it to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_READ   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WBACK  = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

endpackage

// File: rtl/exec_counter.sv
// 2-bit loadable down-counter that times the EXEC phase; zero marks the last EXEC cycle.
module exec_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 2'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign zero = (cnt_q == 2'd0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle ADDR/READ/DECODE/EXEC/WBACK sequencer producing datapath strobes.
// Optional SINGLE_STEP_EN: each start runs one instruction and returns to IDLE.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int                OPW_P     = seq_pkg::OPW,
  parameter logic [OPW_P-1:0]  OP_NOP_P   = OPW_P'(seq_pkg::OP_NOP),
  parameter logic [OPW_P-1:0]  OP_STORE_P = OPW_P'(seq_pkg::OP_STORE),
  parameter logic [OPW_P-1:0]  OP_HLT_P   = OPW_P'(seq_pkg::OP_HLT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW_P-1:0] opcode,
  input  logic             mem_ack,
  output logic             pc_out,
  output logic             mar_in,
  output logic             mem_rd,
  output logic             ir_in,
  output logic             inc_pc,
  output logic             y_in,
  output logic             alu_en,
  output logic             acc_in,
  output logic             mem_wr,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       state
);

`ifdef SINGLE_STEP_EN
  localparam state_e STEP_NEXT = ST_IDLE;
`else
  localparam state_e STEP_NEXT = ST_ADDR;
`endif

  state_e           state_q, state_d;
  logic [OPW_P-1:0] op_q;
  logic             exec_first_q;
  logic             cnt_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exec_first_q <= (state_q == ST_DECODE);
      if (state_q == ST_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // Loaded in DECODE with opcode[1:0], so EXEC lasts opcode[1:0]+1 cycles.
  exec_counter u_exec_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == ST_DECODE),
    .load_val (opcode[1:0]),
    .dec      ((state_q == ST_EXEC) && !cnt_zero),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_out  = 1'b0;
    mar_in  = 1'b0;
    mem_rd  = 1'b0;
    ir_in   = 1'b0;
    inc_pc  = 1'b0;
    y_in    = 1'b0;
    alu_en  = 1'b0;
    acc_in  = 1'b0;
    mem_wr  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        state_d = ST_READ;
      end
      ST_READ: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_in   = 1'b1;
          inc_pc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HLT_P)      state_d = ST_HALT;
        else if (opcode == OP_NOP_P) state_d = STEP_NEXT;
        else                         state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // A one-cycle EXEC is both the first and the last cycle.
        y_in   = exec_first_q;
        alu_en = !exec_first_q || cnt_zero;
        if (cnt_zero) state_d = ST_WBACK;
      end
      ST_WBACK: begin
        if (op_q == OP_STORE_P) begin
          mem_wr = 1'b1;
          if (mem_ack) state_d = STEP_NEXT;
        end else begin
          acc_in  = 1'b1;
          state_d = STEP_NEXT;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (default continuous-run build).
module tb_instr_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] opcode;
  logic       mem_ack;
  logic       pc_out, mar_in, mem_rd, ir_in, inc_pc, y_in, alu_en, acc_in, mem_wr, busy, halted;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_READ = 3'd2, S_DEC = 3'd3,
                         S_EXEC = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [10:0] B_PC  = 11'h400, B_MAR = 11'h200, B_RD  = 11'h100, B_IR  = 11'h080,
                          B_INC = 11'h040, B_Y   = 11'h020, B_ALU = 11'h010, B_ACC = 11'h008,
                          B_WR  = 11'h004, B_BSY = 11'h002, B_HLT = 11'h001, B_NONE = 11'h000;

  localparam logic [10:0] E_ADDR  = B_PC | B_MAR | B_BSY;
  localparam logic [10:0] E_RDACK = B_RD | B_IR | B_INC | B_BSY;
  localparam logic [10:0] E_RDW   = B_RD | B_BSY;

  logic [10:0] obs;
  assign obs = {pc_out, mar_in, mem_rd, ir_in, inc_pc, y_in, alu_en, acc_in, mem_wr, busy, halted};

  instr_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .mem_ack (mem_ack),
    .pc_out  (pc_out),
    .mar_in  (mar_in),
    .mem_rd  (mem_rd),
    .ir_in   (ir_in),
    .inc_pc  (inc_pc),
    .y_in    (y_in),
    .alu_en  (alu_en),
    .acc_in  (acc_in),
    .mem_wr  (mem_wr),
    .busy    (busy),
    .halted  (halted),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [10:0] sb);
    #1;
    n_cmp++;
    assert ({state, obs} === {st, sb}) else begin
      n_bad++;
      $error("FAIL %s: observed state=%0d strobes=%b, expected state=%0d strobes=%b",
             tag, state, obs, st, sb);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opcode = 4'h0; mem_ack = 1'b0;
    chk("reset_state", S_IDLE, B_NONE);
    #20 reset = 1'b1;
    repeat (10) begin
      next(); chk("idle_no_start", S_IDLE, B_NONE);
    end

    // opcode 3, zero-wait memory: ADDR, READ, DECODE, EXEC x4, WBACK, ADDR at cycle 8
    start = 1'b1; opcode = 4'h3; mem_ack = 1'b1;
    next(); chk("op3_addr", S_ADDR, E_ADDR); start = 1'b0;
    next(); chk("op3_read", S_READ, E_RDACK);
    next(); chk("op3_decode", S_DEC, B_BSY);
    next(); chk("op3_exec_first", S_EXEC, B_Y | B_BSY);
    repeat (3) begin
      next(); chk("op3_exec_alu", S_EXEC, B_ALU | B_BSY);
    end
    next(); chk("op3_wback", S_WB, B_ACC | B_BSY);
    next(); chk("op3_next_addr", S_ADDR, E_ADDR);
    opcode = 4'hE;

    // STORE with wait states: ack in ADDR ignored, READ waits 3, WBACK waits 2
    next(); mem_ack = 1'b0; chk("st_read_wait", S_READ, E_RDW);
    repeat (2) begin
      next(); chk("st_read_wait", S_READ, E_RDW);
    end
    next(); mem_ack = 1'b1; chk("st_read_ack", S_READ, E_RDACK);
    next(); chk("st_decode_no_ir", S_DEC, B_BSY);
    next(); mem_ack = 1'b0; opcode = 4'h0; chk("st_exec_first", S_EXEC, B_Y | B_BSY);
    repeat (2) begin
      next(); chk("st_exec_alu", S_EXEC, B_ALU | B_BSY);
    end
    next(); chk("st_wr_wait", S_WB, B_WR | B_BSY);
    next(); chk("st_wr_wait", S_WB, B_WR | B_BSY);
    next(); mem_ack = 1'b1; chk("st_wr_ack", S_WB, B_WR | B_BSY);
    next(); chk("st_next_addr", S_ADDR, E_ADDR);

    // two NOPs, 3 cycles each
    repeat (2) begin
      next(); chk("nop_read", S_READ, E_RDACK);
      next(); chk("nop_decode", S_DEC, B_BSY);
      next(); chk("nop_addr", S_ADDR, E_ADDR);
    end

    // opcode 4: one-cycle EXEC asserts y_in and alu_en together
    opcode = 4'h4;
    next(); chk("op4_read", S_READ, E_RDACK);
    next(); chk("op4_decode", S_DEC, B_BSY);
    next(); chk("op4_exec_single", S_EXEC, B_Y | B_ALU | B_BSY);
    next(); chk("op4_wback", S_WB, B_ACC | B_BSY);
    next(); chk("op4_addr", S_ADDR, E_ADDR);

    // HLT: stays halted while start toggles, reset returns to IDLE
    opcode = 4'hF;
    next(); chk("hlt_read", S_READ, E_RDACK);
    next(); chk("hlt_decode", S_DEC, B_BSY);
    repeat (20) begin
      next(); start = ~start; chk("halt_hold", S_HALT, B_HLT);
    end
    #2 reset = 1'b0; chk("halt_reset", S_IDLE, B_NONE);
    #2 reset = 1'b1; start = 1'b0;
    next(); chk("post_halt_idle", S_IDLE, B_NONE);

    // async reset in the middle of EXEC
    start = 1'b1; opcode = 4'h3; mem_ack = 1'b1;
    next(); chk("r6_addr", S_ADDR, E_ADDR); start = 1'b0;
    next(); chk("r6_read", S_READ, E_RDACK);
    next(); chk("r6_decode", S_DEC, B_BSY);
    next(); chk("r6_exec_first", S_EXEC, B_Y | B_BSY);
    next(); chk("r6_exec_alu", S_EXEC, B_ALU | B_BSY);
    #2 reset = 1'b0; chk("exec_async_reset", S_IDLE, B_NONE);
    #2 reset = 1'b1;
    next(); chk("r6_idle", S_IDLE, B_NONE);

    // restart after the abort: full 4-cycle EXEC again, then reset mid-READ
    start = 1'b1; opcode = 4'h3;
    next(); chk("r7_addr", S_ADDR, E_ADDR); start = 1'b0;
    next(); chk("r7_read", S_READ, E_RDACK);
    next(); chk("r7_decode", S_DEC, B_BSY);
    next(); chk("r7_exec_first", S_EXEC, B_Y | B_BSY);
    repeat (3) begin
      next(); chk("r7_exec_alu", S_EXEC, B_ALU | B_BSY);
    end
    next(); chk("r7_wback", S_WB, B_ACC | B_BSY);
    next(); chk("r7_addr2", S_ADDR, E_ADDR);
    next(); mem_ack = 1'b0; chk("r7_read_wait", S_READ, E_RDW);
    #2 reset = 1'b0; chk("read_async_reset", S_IDLE, B_NONE);
    #2 reset = 1'b1;
    next(); chk("r7_idle", S_IDLE, B_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
